// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB completer among NUM_REQ APB managers
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES.
module apb_rr_arbiter #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 s_psel_i,
  input  logic [NUM_REQ-1:0]                 s_penable_i,
  input  logic [NUM_REQ-1:0]                 s_pwrite_i,
  input  logic [NUM_REQ*ADDR_BUS_WIDTH-1:0]  s_paddr_i,
  input  logic [NUM_REQ*3-1:0]               s_pprot_i,
  input  logic [NUM_REQ*DATA_BUS_WIDTH/8-1:0] s_pstrb_i,
  input  logic [NUM_REQ*DATA_BUS_WIDTH-1:0]  s_pwdata_i,
  output logic [DATA_BUS_WIDTH-1:0]          s_prdata_o,
  output logic [NUM_REQ-1:0]                 s_pready_o,
  output logic                               s_psuberr_o,
  output logic                               m_psel_o,
  output logic                               m_penable_o,
  output logic                               m_pwrite_o,
  output logic [ADDR_BUS_WIDTH-1:0]          m_paddr_o,
  output logic [2:0]                         m_pprot_o,
  output logic [DATA_BUS_WIDTH/8-1:0]        m_pstrb_o,
  output logic [DATA_BUS_WIDTH-1:0]          m_pwdata_o,
  input  logic [DATA_BUS_WIDTH-1:0]          m_prdata_i,
  input  logic                               m_pready_i,
  input  logic                               m_psuberr_i
);
  localparam int STRB_W = DATA_BUS_WIDTH / 8;
  localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             last_grant_q, last_grant_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [ADDR_BUS_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]                pprot_q, pprot_d;
  logic [STRB_W-1:0]         pstrb_q, pstrb_d;
  logic [DATA_BUS_WIDTH-1:0] pwdata_q, pwdata_d;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          done;
  logic          timeout_hit;
  logic          cfg_unused;

  assign cfg_unused = ^s_penable_i ^ (TIMEOUT_CYCLES > 0);

  // Scan from the farthest offset down so the nearest requester after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (s_psel_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == ACCESS && !m_pready_i) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // A late m_pready_i in the expiry cycle still completes normally.
  assign timeout_hit = (state_q == ACCESS) && !m_pready_i &&
                       (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      pstrb_q      <= '0;
      pwdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pprot_q      <= pprot_d;
      pstrb_q      <= pstrb_d;
      pwdata_q     <= pwdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pprot_d      = pprot_q;
    pstrb_d      = pstrb_q;
    pwdata_d     = pwdata_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = SETUP;
          grant_d  = win_idx;
          psel_d   = 1'b1;
          pwrite_d = s_pwrite_i[win_idx];
          paddr_d  = s_paddr_i[win_idx*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
          pprot_d  = s_pprot_i[win_idx*3 +: 3];
          pstrb_d  = s_pstrb_i[win_idx*STRB_W +: STRB_W];
          pwdata_d = s_pwdata_i[win_idx*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (done) begin
          state_d      = IDLE;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    done        = (state_q == ACCESS) && (m_pready_i || timeout_hit);
    s_pready_o  = done ? (NUM_REQ'(1) << grant_q) : '0;
    s_psuberr_o = done && (timeout_hit || m_psuberr_i);
    s_prdata_o  = timeout_hit ? '0 : m_prdata_i;
  end

  assign m_psel_o    = psel_q;
  assign m_penable_o = penable_q;
  assign m_pwrite_o  = pwrite_q;
  assign m_paddr_o   = paddr_q;
  assign m_pprot_o   = pprot_q;
  assign m_pstrb_o   = pstrb_q;
  assign m_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - self-checking bench for apb_rr_arbiter with a cycle-count reference model
module tb_apb_rr_arbiter;
  localparam int N   = 3;
  localparam int TMO = 8;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TMO_LIM = TMO;
`else
  localparam int TMO_LIM = 1 << 30;
`endif

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    s_psel_i, s_penable_i, s_pwrite_i;
  logic [N*32-1:0] s_paddr_i, s_pwdata_i;
  logic [N*3-1:0]  s_pprot_i;
  logic [N*4-1:0]  s_pstrb_i;
  logic [31:0]     s_prdata_o;
  logic [N-1:0]    s_pready_o;
  logic            s_psuberr_o;
  logic            m_psel_o, m_penable_o, m_pwrite_o;
  logic [31:0]     m_paddr_o, m_pwdata_o;
  logic [2:0]      m_pprot_o;
  logic [3:0]      m_pstrb_o;
  logic [31:0]     m_prdata_i;
  logic            m_pready_i, m_psuberr_i;

  apb_rr_arbiter #(
    .ADDR_BUS_WIDTH(32), .DATA_BUS_WIDTH(32), .NUM_REQ(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_psel_i(s_psel_i), .s_penable_i(s_penable_i), .s_pwrite_i(s_pwrite_i),
    .s_paddr_i(s_paddr_i), .s_pprot_i(s_pprot_i), .s_pstrb_i(s_pstrb_i),
    .s_pwdata_i(s_pwdata_i), .s_prdata_o(s_prdata_o), .s_pready_o(s_pready_o),
    .s_psuberr_o(s_psuberr_o), .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
    .m_pwrite_o(m_pwrite_o), .m_paddr_o(m_paddr_o), .m_pprot_o(m_pprot_o),
    .m_pstrb_o(m_pstrb_o), .m_pwdata_o(m_pwdata_o), .m_prdata_i(m_prdata_i),
    .m_pready_i(m_pready_i), .m_psuberr_i(m_psuberr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [N-1:0] mask;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [3:0]   strb;
    int           waits;
    logic [31:0]  rdata;
    logic         err;
    int           n;
    int           ord[3];
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Upstream managers: a raised request holds its attributes until served.
  logic [N-1:0] mreq, raise_mask, drop_mask;
  logic         mwr[N];
  logic [31:0]  maddr[N], mwdata[N];
  logic [3:0]   mstrb[N];
  logic [2:0]   mprot[N];
  int           wait_cnt[N];

  // Reference model: one transfer in flight, described by its start and completion cycles.
  int          cyc = 0, g = 0, last_g = N - 1, t_start = 0, t_done = 0, cur_waits = 0, waits_cfg = 0;
  bit          busy = 0, timed = 0;
  logic [31:0] c_rdata = '0, obs_rd = '0;
  logic        c_err = 1'b0, obs_err = 1'b0;
  int          served_q[$], rdy_cyc_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++) begin
      if (mreq[(last_g + k) % N]) return (last_g + k) % N;
    end
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_psel_i[i]          = mreq[i];
      s_pwrite_i[i]        = mwr[i];
      s_paddr_i[i*32 +: 32]  = maddr[i];
      s_pwdata_i[i*32 +: 32] = mwdata[i];
      s_pstrb_i[i*4 +: 4]  = mstrb[i];
      s_pprot_i[i*3 +: 3]  = mprot[i];
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy;
    logic         exp_psel, exp_pen;
    logic [31:0]  exp_rd;
    logic         exp_err;
    @(posedge clk_i);
    #1;
    cyc++;
    mreq        = (mreq & ~drop_mask) | raise_mask;
    s_penable_i = mreq & ~raise_mask;
    for (int i = 0; i < N; i++) if (raise_mask[i]) wait_cnt[i] = 0;
    drop_mask  = '0;
    raise_mask = '0;
    drive();
    if (!busy && mreq != '0) begin
      g = pick();
      check("fairness", 128'(wait_cnt[g] <= N - 1), 128'(1));
      for (int i = 0; i < N; i++) if (i != g && mreq[i]) wait_cnt[i]++;
      busy      = 1;
      t_start   = cyc;
      cur_waits = (waits_cfg < 0) ? int'($urandom_range(0, 3)) : waits_cfg;
      if (waits_cfg < 0) begin
        c_rdata = $urandom;
        c_err   = 1'($urandom_range(0, 1));
      end
      timed  = cur_waits >= TMO_LIM;
      t_done = t_start + 2 + (timed ? TMO_LIM - 1 : cur_waits);
    end
    m_pready_i  = busy && !timed && (cyc == t_done);
    m_prdata_i  = (busy && cyc == t_done) ? c_rdata : $urandom;
    m_psuberr_i = (busy && cyc == t_done) ? c_err : 1'($urandom_range(0, 1));
    #1;
    exp_psel = busy && (cyc > t_start);
    exp_pen  = busy && (cyc >= t_start + 2);
    exp_rdy  = (busy && cyc == t_done) ? (N'(1) << g) : '0;
    check("m_psel", 128'(m_psel_o), 128'(exp_psel));
    check("m_penable", 128'(m_penable_o), 128'(exp_pen));
    check("s_pready", 128'(s_pready_o), 128'(exp_rdy));
    if (exp_psel) begin
      check("m_bus", {m_pwrite_o, m_pprot_o, m_pstrb_o, m_paddr_o, m_pwdata_o},
            {mwr[g], mprot[g], mstrb[g], maddr[g], mwdata[g]});
    end
    if (busy && cyc == t_done) begin
      exp_rd  = timed ? 32'h0 : m_prdata_i;
      exp_err = timed ? 1'b1 : c_err;
      check("s_resp", {s_prdata_o, s_psuberr_o}, {exp_rd, exp_err});
      served_q.push_back(g);
      rdy_cyc_q.push_back(cyc);
      obs_rd    = s_prdata_o;
      obs_err   = s_psuberr_o;
      drop_mask = N'(1) << g;
      busy      = 0;
      last_g    = g;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    mreq = '0; raise_mask = '0; drop_mask = '0;
    busy = 0; timed = 0; last_g = N - 1;
    drive();
    s_penable_i = '0; m_pready_i = 1'b0; m_psuberr_i = 1'b0; m_prdata_i = '0;
    repeat (2) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    check("reset_state",
          {m_psel_o, m_penable_o, m_pwrite_o, m_pprot_o, m_pstrb_o, m_paddr_o, m_pwdata_o, s_pready_o, s_psuberr_o},
          128'(0));
  endtask

  task automatic run_vec(input vec_t v);
    int raise_c, w_eff, budget;
    for (int i = 0; i < N; i++) begin
      if (v.mask[i]) begin
        mwr[i] = v.wr; maddr[i] = v.addr; mwdata[i] = v.wdata; mstrb[i] = v.strb; mprot[i] = 3'(i);
      end
    end
    waits_cfg = v.waits; c_rdata = v.rdata; c_err = v.err;
    served_q.delete();
    rdy_cyc_q.delete();
    raise_mask = v.mask;
    raise_c    = cyc + 1;
    budget     = 0;
    while ((served_q.size() < v.n || busy) && budget < 300) begin
      step();
      budget++;
    end
    check("vec_served", 128'(served_q.size()), 128'(v.n));
    w_eff = (v.waits >= TMO_LIM) ? TMO_LIM - 1 : v.waits;
    for (int k = 0; k < v.n && k < served_q.size(); k++) begin
      check("grant_order", 128'(served_q[k]), 128'(v.ord[k]));
      check("pready_cycle", 128'(rdy_cyc_q[k] - raise_c), 128'(2 + w_eff + k * (3 + w_eff)));
    end
    if (v.waits >= TMO_LIM) check("timeout_resp", {obs_rd, obs_err}, {32'h0, 1'b1});
    else                    check("vec_resp", {obs_rd, obs_err}, {v.rdata, v.err});
  endtask

  initial begin
    vec_t vecs[7];
    vec_t tv;
    int   budget;
    vecs[0] = '{mask: 3'b111, wr: 1'b0, addr: 32'h100, wdata: 32'h0, strb: 4'h0, waits: 0,
                rdata: 32'hA5A50001, err: 1'b0, n: 3, ord: '{0, 1, 2}};
    vecs[1] = '{mask: 3'b101, wr: 1'b1, addr: 32'h180, wdata: 32'hCAFE0001, strb: 4'h3, waits: 1,
                rdata: 32'h0, err: 1'b0, n: 2, ord: '{0, 2, 0}};
    vecs[2] = '{mask: 3'b010, wr: 1'b0, addr: 32'h40, wdata: 32'h0, strb: 4'h0, waits: 0,
                rdata: 32'hDEADBEEF, err: 1'b0, n: 1, ord: '{1, 0, 0}};
    vecs[3] = '{mask: 3'b100, wr: 1'b1, addr: 32'h200, wdata: 32'h12345678, strb: 4'hF, waits: 3,
                rdata: 32'h0, err: 1'b1, n: 1, ord: '{2, 0, 0}};
    vecs[4] = '{mask: 3'b011, wr: 1'b0, addr: 32'h300, wdata: 32'h0, strb: 4'h0, waits: 2,
                rdata: 32'h0BADF00D, err: 1'b0, n: 2, ord: '{0, 1, 0}};
    vecs[5] = '{mask: 3'b111, wr: 1'b1, addr: 32'h400, wdata: 32'h55AA55AA, strb: 4'h5, waits: 0,
                rdata: 32'h0, err: 1'b1, n: 3, ord: '{2, 0, 1}};
    vecs[6] = '{mask: 3'b110, wr: 1'b0, addr: 32'h500, wdata: 32'h0, strb: 4'h0, waits: 1,
                rdata: 32'h13579BDF, err: 1'b0, n: 2, ord: '{2, 1, 0}};

    for (int i = 0; i < N; i++) begin
      mwr[i] = 1'b0; maddr[i] = '0; mwdata[i] = '0; mstrb[i] = '0; mprot[i] = '0; wait_cnt[i] = 0;
    end
    do_reset();
    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset in the middle of a 5-wait-state ACCESS: no completion pulse, priority restarts at manager 0.
    mwr[2] = 1'b1; maddr[2] = 32'h600; mwdata[2] = 32'h89ABCDEF; mstrb[2] = 4'hF; mprot[2] = 3'd2;
    waits_cfg  = 5;
    raise_mask = 3'b100;
    for (int k = 0; k < 6; k++) step();
    #1;
    m_pready_i = 1'b1;
    rst_i      = 1'b1;
    #1;
    check("reset_mid_access", {m_psel_o, m_penable_o, s_pready_o}, 128'(0));
    do_reset();
    tv = '{mask: 3'b011, wr: 1'b0, addr: 32'h700, wdata: 32'h0, strb: 4'h0, waits: 0,
           rdata: 32'h2468ACE0, err: 1'b0, n: 2, ord: '{0, 1, 0}};
    run_vec(tv);

    // Randomized traffic from all managers with random completer wait states.
    waits_cfg = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ((!mreq[i] || drop_mask[i]) && !raise_mask[i] && $urandom_range(0, 3) == 0) begin
          mwr[i] = 1'($urandom_range(0, 1)); maddr[i] = $urandom; mwdata[i] = $urandom;
          mstrb[i] = 4'($urandom_range(0, 15)); mprot[i] = 3'($urandom_range(0, 7));
          raise_mask[i] = 1'b1;
        end
      end
      step();
    end
    budget = 0;
    while ((busy || (mreq & ~drop_mask) != '0) && budget < 100) begin
      step();
      budget++;
    end
    check("random_drain", 128'(busy), 128'(0));
    step();

`ifdef APB_ARB_TIMEOUT_EN
    tv = '{mask: 3'b001, wr: 1'b0, addr: 32'h800, wdata: 32'h0, strb: 4'h0, waits: 20,
           rdata: 32'hFFFFFFFF, err: 1'b0, n: 1, ord: '{0, 0, 0}};
    run_vec(tv);
    tv = '{mask: 3'b010, wr: 1'b0, addr: 32'h804, wdata: 32'h0, strb: 4'h0, waits: TMO - 1,
           rdata: 32'h0F0F0F0F, err: 1'b0, n: 1, ord: '{1, 0, 0}};
    run_vec(tv);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
